uart_tx: RTL and testbench

//  Serial UART transmitter, directly downstream of the message register.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_baud_gen.sv | 30 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and transmitter state encoding.
// Also intended for the receiver side of the link.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        IDLE_LINE = 1'b1;
  localparam logic        START_LVL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: bit_tick is high on the last clk cycle of every bit period.
// The counter is held at zero whenever en is low, so each frame starts aligned.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic clk,
  input  logic nRst,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  // bit_tick is registered one cycle ahead so it lines up with cnt == CLKS_PER_BIT-1
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= (cnt == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt + CNT_W'(1);
      bit_tick <= (cnt == CNT_W'(CLKS_PER_BIT - 2));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per tx_ctrl/tx_ready handshake, 8N1 LSB first.
// Define UART_PARITY_EN to insert a parity bit (8E1 / 8O1 chosen by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       tx_ctrl,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter combination");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 stop_cnt;
  logic                 bit_tick;
`ifdef UART_PARITY_EN
  logic                 par_bit;
`endif

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .nRst     (nRst),
    .en       (tx_busy),
    .bit_tick (bit_tick)
  );

  // Built from flops only: the last cycle of the final stop bit
  assign tx_done = bit_tick && (state == STOP) && (stop_cnt == STOP_LAST);

  // Frame sequencer; the line level for the next bit is registered on each bit_tick
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      tx_serial <= IDLE_LINE;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_serial <= IDLE_LINE;
          if (tx_ctrl && tx_ready) begin
            state     <= START;
            shreg     <= tx_byte;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            tx_serial <= START_LVL;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
`ifdef UART_PARITY_EN
            par_bit   <= (^tx_byte) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (bit_tick) begin
            state     <= DATA;
            tx_serial <= shreg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx   <= '0;
`ifdef UART_PARITY_EN
              state     <= PARITY;
              tx_serial <= par_bit;
`else
              state     <= STOP;
              tx_serial <= IDLE_LINE;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shreg     <= {1'b0, shreg[DATA_BITS-1:1]};
              tx_serial <= shreg[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state     <= STOP;
            tx_serial <= IDLE_LINE;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == STOP_LAST) begin
              state    <= IDLE;
              stop_cnt <= 1'b0;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= IDLE_LINE;
          tx_ready  <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus pushes expected frames, a monitor checks the line.
// Reference frames are built from the framing rules (start, LSB-first data, optional parity, stop).
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int STOPB = 1;
  localparam int PODD  = 0;
`ifdef UART_PARITY_EN
  localparam int PARB  = 1;
`else
  localparam int PARB  = 0;
`endif
  localparam int NBITS = 1 + 8 + PARB + STOPB;
  localparam int F     = NBITS * CPB;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       tx_ctrl = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx_serial, tx_busy, tx_done;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (STOPB),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .tx_ctrl   (tx_ctrl),
    .tx_byte   (tx_byte),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } item_t;

  item_t sbq[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    next_free = 0;
  int    last_done = -1;
  int    prev_done = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line level for bit slot idx of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PARB == 1 && idx == 9) return (^b) ^ 1'(PODD);
    return 1'b1;
  endfunction

  // Monitor: pops an expected frame when the DUT starts one, then checks it cycle by cycle
  initial begin
    bit    in_frame = 1'b0;
    int    pos = 0;
    item_t cur;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        prev_done = last_done;
        last_done = cyc;
      end
      if (!nRst) begin
        in_frame = 1'b0;
        chk("rst_serial", tx_serial, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
      end else begin
        if (!in_frame && (tx_serial === 1'b0 || (sbq.size() > 0 && cyc >= sbq[0].acc))) begin
          if (sbq.size() == 0) begin
            chk("spurious_start", tx_serial, 1);
          end else begin
            cur = sbq.pop_front();
            chk("start_latency", cyc, cur.acc);
            in_frame = 1'b1;
            pos = 0;
          end
        end
        if (in_frame) begin
          chk("line", tx_serial, frame_bit(cur.b, pos / CPB));
          chk("busy", tx_busy, 1);
          chk("ready", tx_ready, 0);
          chk("done", tx_done, (pos == F - 1));
          pos++;
          if (pos == F) in_frame = 1'b0;
        end else begin
          chk("idle_serial", tx_serial, 1);
          chk("idle_ready", tx_ready, 1);
          chk("idle_busy", tx_busy, 0);
          chk("idle_done", tx_done, 0);
        end
      end
    end
  end

  // One cycle of stimulus; the model decides whether the upcoming edge accepts
  task automatic drive(input logic c, input logic [7:0] b, output bit accepted);
    @(negedge clk);
    tx_ctrl  = c;
    tx_byte  = b;
    accepted = 1'b0;
    if (c && nRst && cyc >= next_free) begin
      sbq.push_back('{b: b, acc: cyc + 1});
      next_free = cyc + 1 + F;
      accepted  = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), a);
  endtask

  // Hold tx_ctrl high until the byte is taken; tx_ctrl is left high afterwards
  task automatic send(input logic [7:0] b);
    bit a = 1'b0;
    for (int i = 0; i < 2 * F + 4 && !a; i++) drive(1'b1, b, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cycle %0d no finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    nRst = 1'b0;
    idle(3);
    @(negedge clk);
    nRst = 1'b1;
    idle(4);

    send(8'h55);
    idle(F + 2);

    send(8'hA3);
    for (int i = 0; i < 12; i++) drive(1'b1, 8'hA3, a);
    send(8'h00);
    idle(F + 2);

    send(8'hFF);
    for (int i = 0; i < 17; i++) drive(1'b0, 8'h00, a);
    #2;
    nRst = 1'b0;
    #1;
    chk("abort_serial", tx_serial, 1);
    chk("abort_done", tx_done, 0);
    chk("abort_busy", tx_busy, 0);
    sbq.delete();
    next_free = 0;
    idle(3);
    @(negedge clk);
    nRst = 1'b1;
    idle(2);
    send(8'h0F);
    idle(F + 2);

    send(8'h01);
    idle(2);
    send(8'h03);
    idle(F + 2);

    send(8'h12);
    send(8'h34);
    idle(F + 3);
    chk("done_spacing", last_done - prev_done, F + 1);

    for (int k = 0; k < 20; k++) begin
      send(8'($urandom));
      if ($urandom_range(0, 3) != 0) idle($urandom_range(0, F + 6));
    end
    idle(F + 4);
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
